rc4_prga_decrypt: RTL and testbench

RC4_PRGA_DECRYPT -- requirements
Module: rc4_prga_decrypt

---
 rtl/rc4_prga_decrypt.sv | 76 +++++++
 tb/tb_rc4_prga_decrypt.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt: RC4 keystream generation over a pre-scheduled S-box, XOR-decrypting MSG_LEN ROM bytes into a message RAM.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       finish,
  output logic [7:0] s_address,
  input  logic [7:0] s_q,
  output logic [7:0] s_data,
  output logic       s_wren,
  output logic [4:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [4:0] d_address,
  output logic [7:0] d_data,
  output logic       d_wren
);
  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, CAP_SI, RD_SJ, CAP_SJ, WR_SI, WR_SJ, RD_F, CAP_F, WR_D, DONE
  } state_t;
  localparam logic [4:0] LAST = 5'(MSG_LEN - 1);
  state_t     r_state, w_next;
  logic [7:0] r_i, r_j, r_si, r_sj, r_f, w_sum;
  logic [4:0] r_k;
  logic       w_run;
  assign w_sum = r_si + r_sj;
  assign w_run = !reset;
  always_comb begin
    w_next = (r_state == IDLE)  ? (start ? INC_I : IDLE) :
             (r_state == WR_D)  ? ((r_k == LAST) ? DONE : INC_I) :
             (r_state == DONE)  ? (start ? DONE : IDLE) :
             state_t'(r_state + 4'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_f     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
        end
        INC_I:  r_i <= r_i + 8'd1;
        CAP_SI: begin
          r_si <= s_q;
          r_j  <= r_j + s_q;
        end
        CAP_SJ: r_sj <= s_q;
        CAP_F:  r_f <= s_q;
        WR_D:   if (r_k != LAST) r_k <= r_k + 5'd1;
        default: ;
      endcase
    end
  end
  // Outputs are decoded from state and forced low during reset so no write can land in the reset clock.
  assign finish      = w_run && (r_state == DONE);
  assign s_wren      = w_run && (r_state == WR_SI || r_state == WR_SJ);
  assign s_address   = !w_run ? '0 :
                       (r_state == RD_SI || r_state == WR_SI) ? r_i :
                       (r_state == RD_SJ || r_state == WR_SJ) ? r_j :
                       (r_state == RD_F) ? w_sum : '0;
  assign s_data      = !w_run ? '0 : (r_state == WR_SI) ? r_sj : (r_state == WR_SJ) ? r_si : '0;
  assign rom_address = (w_run && (r_state == RD_F || r_state == CAP_F || r_state == WR_D)) ? r_k : '0;
  assign d_wren      = w_run && (r_state == WR_D);
  assign d_address   = d_wren ? r_k : '0;
  assign d_data      = d_wren ? (r_f ^ rom_q) : '0;
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb_rc4_prga_decrypt: drives MSG_LEN=3 passes over behavioural S/ROM/D memories and scoreboards every message write.
module tb_rc4_prga_decrypt;
  localparam int N = 3;
  logic       clk = 1'b0, reset, start, finish, s_wren, d_wren, do_init;
  logic [7:0] s_address, s_q, s_data, rom_q, d_data;
  logic [4:0] rom_address, d_address;
  logic [7:0] s_mem [256];
  logic [7:0] m_s [256];
  logic [7:0] rom_mem [32];
  logic [31:0] d_written;
  int checks = 0, errors = 0, cyc;
  typedef struct packed {logic [4:0] a; logic [7:0] d;} exp_t;
  exp_t q[$];
  typedef struct packed {logic [23:0] rom; logic [23:0] exp;} vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  rc4_prga_decrypt #(.MSG_LEN(N)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .s_address(s_address), .s_q(s_q), .s_data(s_data), .s_wren(s_wren),
    .rom_address(rom_address), .rom_q(rom_q),
    .d_address(d_address), .d_data(d_data), .d_wren(d_wren)
  );

  always @(posedge clk) begin
    s_q   <= s_mem[s_address];
    rom_q <= rom_mem[rom_address];
    if (do_init) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
      d_written <= '0;
    end else begin
      if (s_wren) s_mem[s_address] <= s_data;
      if (d_wren) d_written[d_address] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (d_wren) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL dwrite unexpected addr %0h data %0h", d_address, d_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (d_address !== e.a || d_data !== e.d) begin
          errors++;
          $display("FAIL dwrite got %0h:%0h want %0h:%0h", d_address, d_data, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_pass(input bit push);
    logic [7:0] i, j, t;
    i = 0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      t = m_s[i] + m_s[j];
      if (push) q.push_back('{5'(k), m_s[t] ^ rom_mem[k]});
    end
  endtask

  task automatic chk_sbox();
    int mm = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) mm++;
    chk("sbox_mismatches", mm, 0);
  endtask

  task automatic do_reset(input logic [23:0] rom);
    @(negedge clk);
    reset = 1; start = 0; do_init = 1;
    for (int x = 0; x < 32; x++) rom_mem[x] = 8'h00;
    for (int k = 0; k < N; k++) rom_mem[k] = rom[8*k +: 8];
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    do_init = 0; reset = 0;
  endtask

  task automatic run_pass(input bit pulse, output int c);
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 if (pulse) start = 0;
    c = 0;
    while (c < 400) begin
      @(posedge clk);
      c++;
      #1;
      if (pulse) start = (c == 4);
      if (finish) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{24'h000000, 24'h070502};
    tbl[1] = '{24'h000041, 24'h070543};
    tbl[2] = '{24'h55aaff, 24'h52affd};
    tbl[3] = '{24'h020507, 24'h050005};
    reset = 1; start = 1; do_init = 1;
    for (int x = 0; x < 32; x++) rom_mem[x] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {finish, s_wren, d_wren, s_address, s_data, rom_address, d_address, d_data}, 0);
    chk("rst_state", 32'(dut.r_state), 0);
    do_init = 0; reset = 0; start = 0;
    @(negedge clk);
    chk("idle_finish", finish, 0);

    for (int v = 0; v < 4; v++) begin
      do_reset(tbl[v].rom);
      model_pass(0);
      for (int k = 0; k < N; k++) q.push_back('{5'(k), tbl[v].exp[8*k +: 8]});
      run_pass(0, cyc);
      chk("pass_cycles", cyc, 30);
      chk("done_finish", finish, 1);
      chk("queue_drained", q.size(), 0);
      chk_sbox();
      if (v == 0) begin
        chk("s_final", {s_mem[0], s_mem[1], s_mem[2], s_mem[3], s_mem[4], s_mem[5], s_mem[7]}, 56'h00_01_03_05_04_02_07);
        @(posedge clk);
        #1 chk("done_hold", finish, 1);
        @(negedge clk) start = 0;
        @(posedge clk);
        #1 chk("drop_finish", finish, 0);
        model_pass(1);
        run_pass(0, cyc);
        chk("pass2_cycles", cyc, 30);
        chk("pass2_drained", q.size(), 0);
        chk_sbox();
      end
      @(negedge clk) start = 0;
      @(posedge clk);
    end

    do_reset(24'h000000);
    model_pass(0);
    for (int k = 0; k < N; k++) q.push_back('{5'(k), tbl[0].exp[8*k +: 8]});
    run_pass(1, cyc);
    chk("pulse_cycles", cyc, 30);
    chk("pulse_finish", finish, 1);
    @(posedge clk);
    #1 chk("pulse_idle", finish, 0);
    chk("pulse_drained", q.size(), 0);

    do_reset(24'h000000);
    q.push_back('{5'd0, 8'h02});
    @(negedge clk) start = 1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1 chk("wr_si_active", {s_wren, s_address, s_data}, {1'b1, 8'h02, 8'h03});
    reset = 1;
    #1 chk("rst_wr_outputs", {s_wren, s_address, s_data, d_wren}, 0);
    @(posedge clk);
    #1 chk("rst_mid_state", 32'(dut.r_state), 0);
    chk("rst_mid_regs", {dut.r_i, dut.r_j, dut.r_si, dut.r_sj, dut.r_f, dut.r_k}, 0);
    chk("rst_d_written", d_written[2:0], 3'b001);
    chk("rst_s_unchanged", {s_mem[2], s_mem[3]}, 16'h0203);
    chk("rst_drained", q.size(), 0);
    @(negedge clk) reset = 0; start = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {finish, s_wren, d_wren, 4'(dut.r_state)}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
